// File: rtl/student_fir_feeder.sv
// Sample-side initiator for the student FIR: FIFO-buffered, period-paced issue with a timed completion wait.
// Define STUDENT_FIR_FEEDER_STATS_EN to add the issued/timeout event counters.
module student_fir_feeder #(
   parameter int DATA_SIZE         = 16,
   parameter int DATA_SIZE_FIR_OUT = 32,
   parameter int FIFO_DEPTH        = 8,
   parameter int STROBE_LEN        = 2,
   parameter int TIMEOUT_CYCLES    = 4096
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         s_valid_i,
   output logic                         s_ready_o,
   input  logic [DATA_SIZE-1:0]         s_data_i,
   input  logic [15:0]                  period_i,
   output logic                         fir_valid_strobe_o,
   output logic [DATA_SIZE-1:0]         fir_sample_o,
   input  logic                         fir_valid_strobe_i,
   input  logic [DATA_SIZE_FIR_OUT-1:0] fir_y_i,
   input  logic [DATA_SIZE-1:0]         fir_shift_i,
   output logic                         m_valid_o,
   input  logic                         m_ready_i,
   output logic [DATA_SIZE_FIR_OUT-1:0] m_y_o,
   output logic [DATA_SIZE-1:0]         m_shift_o,
   output logic                         busy_o,
   output logic                         timeout_o
`ifdef STUDENT_FIR_FEEDER_STATS_EN
   ,
   output logic [15:0]                  issued_cnt_o,
   output logic [15:0]                  timeout_cnt_o
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STR_LAST = SW'(STROBE_LEN - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} t_state;

   t_state                 r_state;
   logic [DATA_SIZE-1:0]   r_mem [FIFO_DEPTH];
   logic [AW:0]            r_wr_ptr;
   logic [AW:0]            r_rd_ptr;
   logic                   r_fir_prev;
   logic [15:0]            r_gap;
   logic [SW-1:0]          r_str_cnt;
   logic [TW-1:0]          r_to_cnt;
   logic                   r_strobe;
   logic [DATA_SIZE-1:0]   r_sample;
   logic                   r_m_valid;
   logic [DATA_SIZE_FIR_OUT-1:0] r_m_y;
   logic [DATA_SIZE-1:0]   r_m_shift;
   logic                   r_timeout;
`ifdef STUDENT_FIR_FEEDER_STATS_EN
   logic [15:0]            r_issued_cnt;
   logic [15:0]            r_timeout_cnt;
`endif

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_rise;
   logic w_gap_ok;
   logic w_out_free;
   logic w_issue;

   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push     = s_valid_i && !w_full;
   assign w_rise     = fir_valid_strobe_i && !r_fir_prev;
   assign w_gap_ok   = ({1'b0, r_gap} + 17'd1) >= {1'b0, period_i};
   // A result being handed off this cycle frees the register in time for the next one.
   assign w_out_free = !r_m_valid || m_ready_i;
   assign w_issue    = (r_state == S_IDLE) && !w_empty && w_out_free && w_gap_ok;

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= s_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fir_prev <= 1'b0;
         r_gap      <= 16'hFFFF;
         r_str_cnt  <= '0;
         r_to_cnt   <= '0;
         r_strobe   <= 1'b0;
         r_sample   <= '0;
         r_m_valid  <= 1'b0;
         r_m_y      <= '0;
         r_m_shift  <= '0;
         r_timeout  <= 1'b0;
`ifdef STUDENT_FIR_FEEDER_STATS_EN
         r_issued_cnt  <= '0;
         r_timeout_cnt <= '0;
`endif
      end else begin
         r_fir_prev <= fir_valid_strobe_i;
         r_timeout  <= 1'b0;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (r_m_valid && m_ready_i) r_m_valid <= 1'b0;
         if (w_issue) r_gap <= '0;
         else if (r_gap != 16'hFFFF) r_gap <= r_gap + 16'd1;

         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_rd_ptr  <= r_rd_ptr + 1'b1;
                  r_sample  <= r_mem[r_rd_ptr[AW-1:0]];
                  r_strobe  <= 1'b1;
                  r_str_cnt <= '0;
                  r_to_cnt  <= '0;
                  r_state   <= S_STROBE;
`ifdef STUDENT_FIR_FEEDER_STATS_EN
                  if (r_issued_cnt != 16'hFFFF) r_issued_cnt <= r_issued_cnt + 16'd1;
`endif
               end
            end
            S_STROBE, S_WAIT: begin
               // Completion wins over both the timeout and the end of the strobe window.
               if (w_rise) begin
                  r_m_y     <= fir_y_i;
                  r_m_shift <= fir_shift_i;
                  r_m_valid <= 1'b1;
                  r_strobe  <= 1'b0;
                  r_state   <= S_IDLE;
               end else if (r_to_cnt == TO_LAST) begin
                  r_timeout <= 1'b1;
                  r_strobe  <= 1'b0;
                  r_state   <= S_IDLE;
`ifdef STUDENT_FIR_FEEDER_STATS_EN
                  if (r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 16'd1;
`endif
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
                  if (r_state == S_STROBE) begin
                     if (r_str_cnt == STR_LAST) begin
                        r_strobe <= 1'b0;
                        r_state  <= S_WAIT;
                     end else begin
                        r_str_cnt <= r_str_cnt + 1'b1;
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_ready_o          = !w_full;
   assign fir_valid_strobe_o = r_strobe;
   assign fir_sample_o       = r_sample;
   assign m_valid_o          = r_m_valid;
   assign m_y_o              = r_m_y;
   assign m_shift_o          = r_m_shift;
   assign busy_o             = (r_state != S_IDLE);
   assign timeout_o          = r_timeout;
`ifdef STUDENT_FIR_FEEDER_STATS_EN
   assign issued_cnt_o       = r_issued_cnt;
   assign timeout_cnt_o      = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_student_fir_feeder.sv
// Bench for student_fir_feeder: event-time reference model, per-cycle compare, directed plus random traffic.
module tb_student_fir_feeder;

   localparam int DW    = 16;
   localparam int YW    = 32;
   localparam int DEPTH = 8;
   localparam int SL    = 2;
   localparam int TO    = 200;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic [15:0]   period = '0;
   logic          fir_in = 1'b0;
   logic [YW-1:0] fir_y = '0;
   logic [DW-1:0] fir_shift = '0;
   logic          m_ready = 1'b0;
   logic          s_ready_o, fir_valid_strobe_o, m_valid_o, busy_o, timeout_o;
   logic [DW-1:0] fir_sample_o, m_shift_o;
   logic [YW-1:0] m_y_o;
`ifdef STUDENT_FIR_FEEDER_STATS_EN
   logic [15:0]   issued_cnt_o, timeout_cnt_o;
`endif

   always #5 clk = ~clk;

   student_fir_feeder #(
      .DATA_SIZE(DW), .DATA_SIZE_FIR_OUT(YW), .FIFO_DEPTH(DEPTH),
      .STROBE_LEN(SL), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .s_valid_i(s_valid), .s_ready_o(s_ready_o), .s_data_i(s_data),
      .period_i(period),
      .fir_valid_strobe_o(fir_valid_strobe_o), .fir_sample_o(fir_sample_o),
      .fir_valid_strobe_i(fir_in), .fir_y_i(fir_y), .fir_shift_i(fir_shift),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready),
      .m_y_o(m_y_o), .m_shift_o(m_shift_o),
      .busy_o(busy_o), .timeout_o(timeout_o)
`ifdef STUDENT_FIR_FEEDER_STATS_EN
      , .issued_cnt_o(issued_cnt_o), .timeout_cnt_o(timeout_cnt_o)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO as a queue, issue/timeout expressed as edge numbers.
   longint        cyc = 0;
   logic [DW-1:0] mq[$];
   logic          m_busy, m_strobe, m_full, m_to, m_prev;
   logic [DW-1:0] m_sample, m_shift;
   logic [YW-1:0] m_y;
   longint        t_issue, last_issue;
   int            m_issued, m_tocnt;

   task automatic model_reset();
      m_busy = 0; m_strobe = 0; m_full = 0; m_to = 0; m_prev = 0;
      m_sample = '0; m_shift = '0; m_y = '0;
      mq.delete();
      last_issue = -(longint'(1) << 20);
      t_issue = 0; m_issued = 0; m_tocnt = 0;
   endtask

   initial model_reset();

   always @(posedge clk) begin : model
      logic   rise, push_ok, rel, iss;
      longint g;
      cyc++;
      if (!rst_n) begin
         model_reset();
      end else begin
         rise = fir_in && !m_prev;
         m_prev = fir_in;
         push_ok = s_valid && (mq.size() < DEPTH);
         rel = m_full && m_ready;
         g = cyc - 1 - last_issue;
         if (g > 65535) g = 65535;
         iss = !m_busy && (mq.size() > 0) && (!m_full || m_ready) && (g + 1 >= longint'(period));
         m_to = 0;
         if (rel) m_full = 0;
         if (m_busy) begin
            if (rise) begin
               m_y = fir_y; m_shift = fir_shift; m_full = 1;
               m_busy = 0; m_strobe = 0;
            end else if (cyc - t_issue == TO) begin
               m_to = 1; m_busy = 0; m_strobe = 0;
               if (m_tocnt < 65535) m_tocnt++;
            end else if (cyc - t_issue == SL) begin
               m_strobe = 0;
            end
         end else if (iss) begin
            m_sample = mq.pop_front();
            m_strobe = 1; m_busy = 1;
            t_issue = cyc; last_issue = cyc;
            if (m_issued < 65535) m_issued++;
         end
         if (push_ok) mq.push_back(s_data);
      end
   end

   always @(negedge clk) begin : compare
      chk("s_ready", s_ready_o, mq.size() < DEPTH);
      chk("strobe", fir_valid_strobe_o, m_strobe);
      chk("sample", fir_sample_o, m_sample);
      chk("m_valid", m_valid_o, m_full);
      chk("m_y", m_y_o, m_y);
      chk("m_shift", m_shift_o, m_shift);
      chk("busy", busy_o, m_busy);
      chk("timeout", timeout_o, m_to);
`ifdef STUDENT_FIR_FEEDER_STATS_EN
      chk("issued_cnt", issued_cnt_o, m_issued);
      chk("timeout_cnt", timeout_cnt_o, m_tocnt);
`endif
   end

   // FIR stand-in: answers fir_delay cycles after each strobe rise (never if negative).
   int            fir_delay = 0;
   logic          stray_en = 0;
   logic          rand_resp = 0;
   logic [YW-1:0] resp_y = '0;
   logic [DW-1:0] resp_shift = '0;
   int            cd = -1;
   int            hold = 0;
   logic          prev_so = 0;

   always @(negedge clk) begin : fir_model
      if (fir_valid_strobe_o && !prev_so && fir_delay >= 0) cd = fir_delay;
      else if (cd > 0) cd--;
      prev_so = fir_valid_strobe_o;
      if (cd == 0) begin
         hold = rand_resp ? int'($urandom_range(1, 3)) : 1;
         cd = -1;
      end else if (stray_en && hold == 0 && $urandom_range(0, 30) == 0) begin
         hold = 1;
      end
      fir_in = (hold > 0);
      if (hold > 0) hold--;
      fir_y     = rand_resp ? YW'($urandom) : resp_y;
      fir_shift = rand_resp ? DW'($urandom) : resp_shift;
   end

   // Event log for the directed scenarios.
   longint        rises[$];
   longint        to_times[$];
   logic [DW-1:0] seen[$];
   int            lens[$];
   logic          mon_prev = 0;
   int            hi = 0;

   always @(negedge clk) begin : monitor
      if (fir_valid_strobe_o && !mon_prev) begin
         rises.push_back(cyc);
         seen.push_back(fir_sample_o);
      end
      mon_prev = fir_valid_strobe_o;
      if (fir_valid_strobe_o) hi++;
      else if (hi > 0) begin
         lens.push_back(hi);
         hi = 0;
      end
      if (timeout_o) to_times.push_back(cyc);
   end

   task automatic clear_log();
      rises.delete(); to_times.delete(); seen.delete(); lens.delete();
   endtask

   task automatic push(input logic [DW-1:0] d);
      int n;
      s_valid = 1; s_data = d;
      n = 0;
      while (!s_ready_o && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("push_wait_ready", 0, 1);
      @(negedge clk);
      s_valid = 0;
   endtask

   initial begin : stim
      repeat (3) @(negedge clk);
      chk("rst_s_ready", s_ready_o, 1);
      chk("rst_m_valid", m_valid_o, 0);
      chk("rst_strobe", fir_valid_strobe_o, 0);
      #1 rst_n = 1;
      @(negedge clk);

      // Single sample
      clear_log();
      period = 0; m_ready = 0; fir_delay = 20;
      resp_y = 32'h0000ABCD; resp_shift = 16'h0042;
      push(16'h1234);
      for (int i = 0; i < 60 && !m_valid_o; i++) @(negedge clk);
      chk("t1_m_valid", m_valid_o, 1);
      chk("t1_m_y", m_y_o, 32'h0000ABCD);
      chk("t1_m_shift", m_shift_o, 16'h0042);
      chk("t1_issues", seen.size(), 1);
      chk("t1_sample", (seen.size() > 0) ? seen[0] : 16'hxxxx, 16'h1234);
      chk("t1_strobe_len", (lens.size() > 0) ? lens[0] : -1, SL);
      m_ready = 1;
      @(negedge clk);
      chk("t1_accepted", m_valid_o, 0);

      // Pacing
      clear_log();
      period = 100; fir_delay = 10;
      for (int i = 0; i < 4; i++) push(16'hA100 + 16'(i));
      repeat (520) @(negedge clk);
      chk("t2_issues", rises.size(), 4);
      for (int i = 1; i < 4; i++)
         if (i < rises.size()) chk("t2_period", rises[i] - rises[i-1], 100);

      // Backpressure
      clear_log();
      period = 0; m_ready = 0; fir_delay = 5;
      resp_y = 32'h5555_0003; resp_shift = 16'h0003;
      for (int i = 0; i < 3; i++) push(16'hB000 + 16'(i));
      repeat (60) @(negedge clk);
      chk("t3_one_issue", rises.size(), 1);
      chk("t3_m_valid", m_valid_o, 1);
      chk("t3_m_y", m_y_o, 32'h5555_0003);
      m_ready = 1;
      @(negedge clk);
      chk("t3_next_issue", fir_valid_strobe_o, 1);
      repeat (60) @(negedge clk);
      chk("t3_total", rises.size(), 3);

      // FIFO full, order preserved
      clear_log();
      m_ready = 0; fir_delay = 3;
      for (int i = 0; i < 9; i++) push(16'hA0 + 16'(i));
      chk("t4_full", s_ready_o, 0);
      m_ready = 1;
      push(16'hA9);
      repeat (200) @(negedge clk);
      chk("t4_count", seen.size(), 10);
      for (int i = 0; i < 10; i++)
         if (i < seen.size()) chk("t4_order", seen[i], 16'hA0 + 16'(i));

      // Timeout, then stray completions in IDLE
      clear_log();
      fir_delay = -1;
      push(16'hC001);
      push(16'hC002);
      for (int i = 0; i < 3 * TO && to_times.size() < 2; i++) @(negedge clk);
      @(negedge clk);
      chk("t5_timeouts", to_times.size(), 2);
      chk("t5_issues", rises.size(), 2);
      if (to_times.size() > 0 && rises.size() > 0) chk("t5_to_latency0", to_times[0] - rises[0], TO);
      if (to_times.size() > 1 && rises.size() > 1) chk("t5_to_latency1", to_times[1] - rises[1], TO);
      chk("t5_no_result", m_valid_o, 0);
      stray_en = 1;
      repeat (150) @(negedge clk);
      stray_en = 0;
      repeat (5) @(negedge clk);
      chk("t5_stray_m_valid", m_valid_o, 0);

      // Reset during WAIT
      fir_delay = 30;
      push(16'hD001);
      repeat (8) @(negedge clk);
      chk("t6_busy_before", busy_o, 1);
      #1 rst_n = 0;
      @(negedge clk);
      chk("t6_strobe", fir_valid_strobe_o, 0);
      chk("t6_sample", fir_sample_o, 0);
      chk("t6_busy", busy_o, 0);
      chk("t6_s_ready", s_ready_o, 1);
      chk("t6_m_y", m_y_o, 0);
`ifdef STUDENT_FIR_FEEDER_STATS_EN
      chk("t6_issued_cnt", issued_cnt_o, 0);
`endif
      #1 rst_n = 1;
      repeat (50) @(negedge clk);
      chk("t6_late_completion", m_valid_o, 0);

      // Random traffic
      rand_resp = 1; stray_en = 1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c == 1500) begin
            #1 rst_n = 0;
            @(negedge clk);
            #1 rst_n = 1;
         end
         s_valid = ($urandom_range(0, 2) == 0);
         s_data  = DW'($urandom);
         m_ready = ($urandom_range(0, 9) < 7);
         fir_delay = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 25));
         if ($urandom_range(0, 199) == 0) begin
            case ($urandom_range(0, 4))
               0: period = 16'd0;
               1: period = 16'd1;
               2: period = 16'd2;
               3: period = 16'd5;
               default: period = 16'd17;
            endcase
         end
      end
      s_valid = 0; m_ready = 1; stray_en = 0; fir_delay = 2;
      repeat (300) @(negedge clk);
      chk("drain_idle", busy_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
